// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM state encoding and default width.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;
    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b00111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned engine: shift-add multiply or restoring divide on operand magnitudes,
// one bit per clock. The caller owns the iteration counter and sign handling.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int  WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] mag_a,
    input  logic [WIDTH-1:0] mag_b,
    input  logic [CNT_W-1:0] count,
    output logic             done,
    output logic [WIDTH-1:0] result_mag,
    output logic [WIDTH-1:0] high_mag
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    logic             busy;
    logic             div_mode;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // hi:lo is the running product (multiply) or remainder:quotient (divide).
    always_comb begin
        hi_next = hi;
        lo_next = lo;
        add_sum = '0;
        shifted = '0;
        trial   = '0;
        if (div_mode) begin
            shifted = {hi, lo[WIDTH-1]};
            trial   = shifted - {1'b0, operand};
            if (!trial[WIDTH]) begin
                hi_next = trial[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = shifted[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            add_sum            = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
            {hi_next, lo_next} = {add_sum, lo[WIDTH-1:1]};
        end
    end

    // Outputs expose the post-iteration values so the final step lands in the caller's register.
    assign done       = busy && (count == LAST_COUNT);
    assign result_mag = lo_next;
    assign high_mag   = hi_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            div_mode <= 1'b0;
            operand  <= '0;
            hi       <= '0;
            lo       <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            div_mode <= is_div;
            operand  <= is_div ? mag_b : mag_a;
            hi       <= '0;
            lo       <= is_div ? mag_a : mag_b;
        end else if (busy) begin
            hi <= hi_next;
            lo <= lo_next;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU with valid/ready handshakes: single-cycle arithmetic/logic/shift ops plus
// iterative signed multiply and divide, all results and flags registered.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int  WIDTH   = DEFAULT_WIDTH,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [WIDTH-1:0]   data_operandB,
    input  logic [4:0]         ctrl_ALUopcode,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_result,
    output logic               isNotEqual,
    output logic               isLessThan,
    output logic               overflow,
    output logic               exception
);

    localparam int MSB   = WIDTH - 1;
    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    logic             accept;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic             is_mul;
    logic             is_div;
    logic             b_zero;
    logic             div_by_zero;
    logic [WIDTH-1:0] single_result;
    logic             single_ovf;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             result_neg;
    logic [CNT_W-1:0] iter_count;
    logic             engine_start;
    logic             engine_done;
    logic [WIDTH-1:0] engine_lo;
    logic [WIDTH-1:0] engine_hi;
    logic [WIDTH-1:0] muldiv_result;
    logic             muldiv_ovf;

    assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    assign sum     = data_operandA + data_operandB;
    assign diff    = data_operandA - data_operandB;
    assign add_ovf = (data_operandA[MSB] == data_operandB[MSB]) && (sum[MSB] != data_operandA[MSB]);
    assign sub_ovf = (data_operandA[MSB] != data_operandB[MSB]) && (diff[MSB] != data_operandA[MSB]);

    assign is_mul       = (ctrl_ALUopcode == OP_MUL);
    assign is_div       = (ctrl_ALUopcode == OP_DIV);
    assign b_zero       = (data_operandB == '0);
    assign div_by_zero  = is_div && b_zero;
    assign engine_start = accept && (is_mul || (is_div && !b_zero));

    assign mag_a = data_operandA[MSB] ? -data_operandA : data_operandA;
    assign mag_b = data_operandB[MSB] ? -data_operandB : data_operandB;

    // Divide-by-zero resolves here in a single cycle with a zero result; MUL never takes this path.
    always_comb begin
        single_result = sum;
        single_ovf    = add_ovf;
        case (ctrl_ALUopcode)
            OP_ADD: begin
                single_result = sum;
                single_ovf    = add_ovf;
            end
            OP_SUB: begin
                single_result = diff;
                single_ovf    = sub_ovf;
            end
            OP_AND: begin
                single_result = data_operandA & data_operandB;
                single_ovf    = 1'b0;
            end
            OP_OR: begin
                single_result = data_operandA | data_operandB;
                single_ovf    = 1'b0;
            end
            OP_SLL: begin
                single_result = data_operandA << ctrl_shiftamt;
                single_ovf    = 1'b0;
            end
            OP_SRA: begin
                single_result = $signed(data_operandA) >>> ctrl_shiftamt;
                single_ovf    = 1'b0;
            end
            OP_DIV: begin
                single_result = '0;
                single_ovf    = 1'b0;
            end
            default: ;
        endcase
    end

    // Sign fixup of the engine's magnitude; a negative product may reach exactly MIN without overflow.
    always_comb begin
        muldiv_result = result_neg ? -engine_lo : engine_lo;
        if (state == S_DIV) begin
            muldiv_ovf = !result_neg && engine_lo[MSB];
        end else if (result_neg) begin
            muldiv_ovf = (|engine_hi) || (engine_lo[MSB] && (|engine_lo[MSB-1:0]));
        end else begin
            muldiv_ovf = (|engine_hi) || engine_lo[MSB];
        end
    end

    alu_iter_muldiv #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (engine_start),
        .is_div     (is_div),
        .mag_a      (mag_a),
        .mag_b      (mag_b),
        .count      (iter_count),
        .done       (engine_done),
        .result_mag (engine_lo),
        .high_mag   (engine_hi)
    );

    // Accept is only possible in IDLE or DONE, so it takes priority over the per-state behaviour.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            out_valid   <= 1'b0;
            data_result <= '0;
            isNotEqual  <= 1'b0;
            isLessThan  <= 1'b0;
            overflow    <= 1'b0;
            exception   <= 1'b0;
            result_neg  <= 1'b0;
            iter_count  <= '0;
        end else if (accept) begin
            iter_count <= '0;
            isNotEqual <= |diff;
            isLessThan <= diff[MSB] ^ sub_ovf;
            result_neg <= data_operandA[MSB] ^ data_operandB[MSB];
            if (engine_start) begin
                state     <= is_mul ? S_MUL : S_DIV;
                out_valid <= 1'b0;
            end else begin
                state       <= S_DONE;
                out_valid   <= 1'b1;
                data_result <= single_result;
                overflow    <= single_ovf;
                exception   <= div_by_zero;
            end
        end else begin
            case (state)
                S_MUL, S_DIV: begin
                    if (engine_done) begin
                        state       <= S_DONE;
                        out_valid   <= 1'b1;
                        data_result <= muldiv_result;
                        overflow    <= muldiv_ovf;
                        exception   <= 1'b0;
                    end else begin
                        iter_count <= iter_count + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed corner cases, handshake/reset scenarios and
// randomized ops against a plain-arithmetic reference model.
module tb_alu_multicycle;

    localparam int W = 32;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        exc;
        logic        ne;
        logic        lt;
        int          lat;
    } expect_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [4:0]  ctrl_ALUopcode = '0;
    logic [4:0]  ctrl_shiftamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] data_result;
    logic        isNotEqual;
    logic        isLessThan;
    logic        overflow;
    logic        exception;

    int assertCount = 0;
    int failCount = 0;

    always #5 clock = ~clock;

    alu_multicycle #(
        .WIDTH(W)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_ALUopcode (ctrl_ALUopcode),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .data_result    (data_result),
        .isNotEqual     (isNotEqual),
        .isLessThan     (isLessThan),
        .overflow       (overflow),
        .exception      (exception)
    );

    // Reference model: full-precision signed arithmetic, then truncate and range-check.
    function automatic expect_t model(input logic [4:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [4:0] sh);
        expect_t e;
        longint  sa;
        longint  sb;
        longint  full;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        e.ne  = (a != b);
        e.lt  = (sa < sb);
        e.exc = 1'b0;
        e.ovf = 1'b0;
        e.lat = 1;
        case (op)
            5'd1: begin
                full  = sa - sb;
                e.res = full[31:0];
                e.ovf = (full != longint'($signed(e.res)));
            end
            5'd2: e.res = a & b;
            5'd3: e.res = a | b;
            5'd4: e.res = a << sh;
            5'd5: e.res = $signed(a) >>> sh;
            5'd6: begin
                full  = sa * sb;
                e.res = full[31:0];
                e.ovf = (full != longint'($signed(e.res)));
                e.lat = W + 1;
            end
            5'd7: begin
                if (b == 32'd0) begin
                    e.res = '0;
                    e.exc = 1'b1;
                end else begin
                    full  = sa / sb;
                    e.res = full[31:0];
                    e.ovf = (full != longint'($signed(e.res)));
                    e.lat = W + 1;
                end
            end
            default: begin
                full  = sa + sb;
                e.res = full[31:0];
                e.ovf = (full != longint'($signed(e.res)));
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 20)) - 32'd10;
            3: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issues one op once in_ready is high; returns clock edges from accept until out_valid.
    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, output int latency);
        int guard;
        guard = 0;
        @(negedge clock);
        while (!in_ready && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        checkOutput("in_ready_at_issue", {31'b0, in_ready}, 32'd1);
        ctrl_ALUopcode = op;
        data_operandA  = a;
        data_operandB  = b;
        ctrl_shiftamt  = sh;
        in_valid       = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        latency  = 1;
        while (!out_valid && latency < 200) begin
            @(posedge clock);
            #1;
            latency++;
        end
    endtask

    task automatic expectResult(input string tag, input expect_t e, input int latency);
        checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        checkOutput({tag, "_result"}, data_result, e.res);
        checkOutput({tag, "_overflow"}, {31'b0, overflow}, {31'b0, e.ovf});
        checkOutput({tag, "_exception"}, {31'b0, exception}, {31'b0, e.exc});
        checkOutput({tag, "_isNotEqual"}, {31'b0, isNotEqual}, {31'b0, e.ne});
        checkOutput({tag, "_isLessThan"}, {31'b0, isLessThan}, {31'b0, e.lt});
        checkOutput({tag, "_latency"}, 32'(latency), 32'(e.lat));
    endtask

    task automatic finishHandshake(input string tag);
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
        checkOutput({tag, "_ready_idle"}, {31'b0, in_ready}, 32'd1);
    endtask

    task automatic runDirected(input string tag, input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] sh, input logic [31:0] res,
                               input logic ovf, input logic exc, input logic ne, input logic lt,
                               input int lat);
        expect_t e;
        int      latency;
        e.res = res;
        e.ovf = ovf;
        e.exc = exc;
        e.ne  = ne;
        e.lt  = lt;
        e.lat = lat;
        applyStimulus(op, a, b, sh, latency);
        expectResult(tag, e, latency);
        finishHandshake(tag);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        expect_t     e;
        int          latency;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        int          r;

        $display("[TB] starting alu_multicycle test");
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("reset_result", data_result, 32'd0);
        checkOutput("reset_flags", {28'b0, isNotEqual, isLessThan, overflow, exception}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        runDirected("add_ovf", 5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 1, 0, 1, 0, 1);
        runDirected("sub_neg", 5'd1, 32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE, 0, 0, 1, 1, 1);
        runDirected("sub_ovf", 5'd1, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF, 1, 0, 1, 1, 1);
        runDirected("sub_eq", 5'd1, 32'd9, 32'd9, 5'd0, 32'd0, 0, 0, 0, 0, 1);
        runDirected("and", 5'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'h00F0_1200, 0, 0, 1, 1, 1);
        runDirected("or", 5'd3, 32'h0000_00F0, 32'h0000_000F, 5'd0, 32'h0000_00FF, 0, 0, 1, 0, 1);
        runDirected("sll", 5'd4, 32'd1, 32'd0, 5'd31, 32'h8000_0000, 0, 0, 1, 0, 1);
        runDirected("illegal_add", 5'd31, 32'd3, 32'd4, 5'd0, 32'd7, 0, 0, 1, 1, 1);
        runDirected("mul_neg", 5'd6, 32'hFFFF_FFFD, 32'd7, 5'd0, 32'hFFFF_FFEB, 0, 0, 1, 1, 33);
        runDirected("mul_ovf", 5'd6, 32'h0001_0000, 32'h0001_0000, 5'd0, 32'd0, 1, 0, 0, 0, 33);
        runDirected("div_neg", 5'd7, 32'hFFFF_FFF9, 32'd2, 5'd0, 32'hFFFF_FFFD, 0, 0, 1, 1, 33);
        runDirected("div_zero", 5'd7, 32'd5, 32'd0, 5'd0, 32'd0, 0, 1, 1, 0, 1);
        runDirected("div_min", 5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h8000_0000, 1, 0, 1, 1, 33);

        // Result held under backpressure, then a new op accepted in the handshake cycle.
        applyStimulus(5'd6, 32'd6, 32'd7, 5'd0, latency);
        expectResult("hold_mul", model(5'd6, 32'd6, 32'd7, 5'd0), latency);
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            #1;
            checkOutput("hold_result", data_result, 32'd42);
            checkOutput("hold_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        @(negedge clock);
        out_ready      = 1'b1;
        ctrl_ALUopcode = 5'd5;
        data_operandA  = 32'h8000_0000;
        data_operandB  = 32'd0;
        ctrl_shiftamt  = 5'd4;
        in_valid       = 1'b1;
        #1;
        checkOutput("b2b_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        e = model(5'd5, 32'h8000_0000, 32'd0, 5'd4);
        checkOutput("b2b_model_sanity", e.res, 32'hF800_0000);
        expectResult("b2b_sra", e, 1);
        finishHandshake("b2b_sra");

        // Reset in the middle of a divide.
        @(negedge clock);
        ctrl_ALUopcode = 5'd7;
        data_operandA  = 32'd1000;
        data_operandB  = 32'd7;
        in_valid       = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_mid_result", data_result, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            checkOutput("rst_no_stale_valid", {31'b0, out_valid}, 32'd0);
        end
        runDirected("post_rst_add", 5'd0, 32'd2, 32'd2, 5'd0, 32'd4, 0, 0, 0, 0, 1);

        for (int i = 0; i < 40; i++) begin
            r  = int'($urandom_range(0, 9));
            op = (r < 8) ? 5'(r) : 5'($urandom_range(8, 31));
            a  = pickOperand();
            b  = pickOperand();
            sh = 5'($urandom_range(0, 31));
            e  = model(op, a, b, sh);
            applyStimulus(op, a, b, sh, latency);
            expectResult($sformatf("rand%0d_op%0d", i, op), e, latency);
            finishHandshake($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
